// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the two-byte-instruction load/store core:
//   - opcode_e : instruction opcodes (upper nibble of opcode1)
//   - JC_*     : jump-condition codes (lower nibble of opcode1 for JMP)
//   - state_e  : core FSM states
//   - jmp_taken: jump-condition evaluator against the Z/C flags
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JMP  = 4'h4,
        OP_ADD  = 4'h8,
        OP_SUB  = 4'h9,
        OP_AND  = 4'hA,
        OP_OR   = 4'hB,
        OP_XOR  = 4'hC,
        OP_HALT = 4'hF
    } opcode_e;

    localparam logic [3:0] JC_ALWAYS = 4'h0;
    localparam logic [3:0] JC_Z_SET  = 4'h5;
    localparam logic [3:0] JC_Z_CLR  = 4'h6;
    localparam logic [3:0] JC_C_SET  = 4'h7;
    localparam logic [3:0] JC_C_CLR  = 4'h8;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    // Unlisted condition codes are never taken.
    function automatic logic jmp_taken(input logic [3:0] cond,
                                       input logic       z,
                                       input logic       c);
        logic t;
        case (cond)
            JC_ALWAYS: t = 1'b1;
            JC_Z_SET:  t = z;
            JC_Z_CLR:  t = ~z;
            JC_C_SET:  t = c;
            JC_C_CLR:  t = ~c;
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// ----------------------------------------------------------------------------
// cpu_alu
// Combinational 8-bit ALU for the register-register instructions.
// Ports:
//   a_i, b_i  [7:0] : operands (R[a], R[b])
//   op_i      [3:0] : instruction opcode; only ADD/SUB/AND/OR/XOR are meaningful
//   result_o  [7:0] : op result, modulo 256
//   z_o             : result == 0
//   c_o             : carry-out (ADD), borrow a<b (SUB), 0 for logic ops
// ----------------------------------------------------------------------------
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [3:0] op_i,
    output logic [7:0] result_o,
    output logic       z_o,
    output logic       c_o
);

    logic [8:0] wide;

    always_comb begin
        wide = 9'd0;
        case (op_i)
            OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
            // Bit 8 of the 9-bit difference is the borrow.
            OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
            OP_AND:  wide = {1'b0, a_i & b_i};
            OP_OR:   wide = {1'b0, a_i | b_i};
            OP_XOR:  wide = {1'b0, a_i ^ b_i};
            default: wide = 9'd0;
        endcase
    end

    assign result_o = wide[7:0];
    assign c_o      = wide[8];
    assign z_o      = (wide[7:0] == 8'd0);

endmodule

// File: rtl/cpu.sv
// ----------------------------------------------------------------------------
// cpu
// Minimal 8-bit load/store core. Two clocks per instruction (FETCH, EXEC),
// 16x8 register file, 256x8 data memory, Z/C flags, external combinational ROM.
// Ports:
//   clk              : clock, rising edge
//   reset            : asynchronous, active-low reset
//   opcode1    [7:0] : ROM byte at rom_address   {op, a}
//   opcode2    [7:0] : ROM byte at rom_address+1 {b, c} / immediate k
//   rom_address[7:0] : program counter (registered)
// Build option:
//   CPU_HALT_EN : opcode 1111 halts the core until reset; otherwise it is a NOP.
// ----------------------------------------------------------------------------
module cpu
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] opcode1,
    input  logic [7:0] opcode2,
    output logic [7:0] rom_address
);

    state_e      state_q;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q;
    logic        z_q, c_q;
    logic [7:0]  regs_q [16];
    logic [7:0]  mem_q  [256];

    logic [3:0]  op, ra, rb, rc;
    logic [7:0]  k;
    logic [7:0]  alu_res;
    logic        alu_z, alu_c;
    logic        is_alu, halt_now;
    logic        rf_wen_d;
    logic [3:0]  rf_waddr_d;
    logic [7:0]  rf_wdata_d;

    assign op = ir_q[15:12];
    assign ra = ir_q[11:8];
    assign rb = ir_q[7:4];
    assign rc = ir_q[3:0];
    assign k  = ir_q[7:0];

    assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                    (op == OP_OR)  || (op == OP_XOR);

`ifdef CPU_HALT_EN
    assign halt_now = (op == OP_HALT);
`else
    assign halt_now = 1'b0;
`endif

    cpu_alu u_alu (
        .a_i      (regs_q[ra]),
        .b_i      (regs_q[rb]),
        .op_i     (op),
        .result_o (alu_res),
        .z_o      (alu_z),
        .c_o      (alu_c)
    );

    // Next PC: jumps use the flags as they stand before this EXEC edge.
    always_comb begin
        pc_d = pc_q + 8'd2;
        if (op == OP_JMP && jmp_taken(ra, z_q, c_q))
            pc_d = k;
        if (halt_now)
            pc_d = pc_q;
    end

    // Register-file write port; LD reads memory combinationally.
    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = ra;
        rf_wdata_d = 8'd0;
        if (op == OP_LDI) begin
            rf_wen_d   = 1'b1;
            rf_wdata_d = k;
        end else if (op == OP_LD) begin
            rf_wen_d   = 1'b1;
            rf_wdata_d = mem_q[k];
        end else if (is_alu) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = rc;
            rf_wdata_d = alu_res;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= 8'd0;
            ir_q    <= 16'd0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < 16; i++)
                regs_q[i] <= 8'd0;
            for (int i = 0; i < 256; i++)
                mem_q[i] <= 8'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_q    <= {opcode1, opcode2};
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    pc_q <= pc_d;
                    if (rf_wen_d)
                        regs_q[rf_waddr_d] <= rf_wdata_d;
                    if (op == OP_ST)
                        mem_q[k] <= regs_q[ra];
                    if (is_alu) begin
                        z_q <= alu_z;
                        c_q <= alu_c;
                    end
                    state_q <= halt_now ? S_HALT : S_FETCH;
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    assign rom_address = pc_q;

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] opcode1, opcode2;
    logic [7:0] rom_address;
    logic [7:0] rom [256];
    logic [7:0] rom_next;

    int n_pass = 0;
    int n_total = 0;

    cpu dut (
        .clk         (clk),
        .reset       (reset),
        .opcode1     (opcode1),
        .opcode2     (opcode2),
        .rom_address (rom_address)
    );

    always #5 clk = ~clk;

    always_comb begin
        rom_next = rom_address + 8'd1;
        opcode1  = rom[rom_address];
        opcode2  = rom[rom_next];
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       c;
    } alu_vec_t;

    alu_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++)
            rom[i] = 8'h00;
    endtask

    task automatic put(input logic [7:0] addr, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] a2;
        a2 = addr + 8'd1;
        rom[addr] = b1;
        rom[a2]   = b2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Checks the address at FETCH and at EXEC of one instruction, then executes it.
    task automatic step(input logic [7:0] addr);
        check("trace_fetch", {24'd0, rom_address}, {24'd0, addr});
        @(posedge clk);
        @(negedge clk);
        check("trace_exec", {24'd0, rom_address}, {24'd0, addr});
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] trace [23];

        vecs[0] = '{4'h8, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[1] = '{4'h9, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1};
        vecs[2] = '{4'hA, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{4'hB, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{4'hC, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0};
        vecs[5] = '{4'h8, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0};
        vecs[6] = '{4'h9, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{4'h9, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1};

        // Reset state
        clear_rom();
        do_reset();
        check("reset_pc", {24'd0, rom_address}, 32'h0);
        check("reset_state", {30'd0, dut.state_q}, {30'd0, cpu_pkg::S_FETCH});
        check("reset_z", {31'd0, dut.z_q}, 32'h0);
        check("reset_r0", {24'd0, dut.regs_q[0]}, 32'h0);

        // ALU vectors: LDI R1=a; LDI R2=b; op R1,R2 -> R3
        for (int v = 0; v < 8; v++) begin
            clear_rom();
            put(8'h00, 8'h11, vecs[v].a);
            put(8'h02, 8'h12, vecs[v].b);
            put(8'h04, {vecs[v].op, 4'h1}, 8'h23);
            do_reset();
            repeat (6) @(negedge clk);
            check($sformatf("alu%0d_res", v), {24'd0, dut.regs_q[3]}, {24'd0, vecs[v].res});
            check($sformatf("alu%0d_z", v), {31'd0, dut.z_q}, {31'd0, vecs[v].z});
            check($sformatf("alu%0d_c", v), {31'd0, dut.c_q}, {31'd0, vecs[v].c});
            check($sformatf("alu%0d_pc", v), {24'd0, rom_address}, 32'h6);
        end

        // Multiply loop, memory, jump conditions, PC wrap
        clear_rom();
        put(8'h00, 8'h10, 8'h03);   // LDI R0,3
        put(8'h02, 8'h11, 8'h04);   // LDI R1,4
        put(8'h04, 8'h12, 8'h00);   // LDI R2,0
        put(8'h06, 8'h13, 8'h01);   // LDI R3,1
        put(8'h08, 8'h80, 8'h22);   // ADD R0+R2->R2
        put(8'h0A, 8'h91, 8'h31);   // SUB R1-R3->R1
        put(8'h0C, 8'h46, 8'h08);   // JMP Z=0 -> 08
        put(8'h0E, 8'h32, 8'h00);   // ST R2 -> MEM[00]
        put(8'h10, 8'h24, 8'h00);   // LD R4 <- MEM[00]
        put(8'h12, 8'h25, 8'h77);   // LD R5 <- MEM[77]
        put(8'h14, 8'h46, 8'h40);   // JMP Z=0 (Z=1, not taken)
        put(8'h16, 8'h4F, 8'h40);   // JMP never
        put(8'h18, 8'h40, 8'hFE);   // JMP always -> FE
        put(8'hFE, 8'h00, 8'h00);   // NOP at FE, wraps to 00
        trace = '{8'h00, 8'h02, 8'h04, 8'h06,
                  8'h08, 8'h0A, 8'h0C, 8'h08, 8'h0A, 8'h0C,
                  8'h08, 8'h0A, 8'h0C, 8'h08, 8'h0A, 8'h0C,
                  8'h0E, 8'h10, 8'h12, 8'h14, 8'h16, 8'h18, 8'hFE};
        do_reset();
        for (int i = 0; i < 23; i++)
            step(trace[i]);
        check("wrap_pc", {24'd0, rom_address}, 32'h0);
        check("mul_r2", {24'd0, dut.regs_q[2]}, 32'd12);
        check("mul_r1", {24'd0, dut.regs_q[1]}, 32'd0);
        check("mul_z", {31'd0, dut.z_q}, 32'h1);
        check("mul_c", {31'd0, dut.c_q}, 32'h0);
        check("st_mem0", {24'd0, dut.mem_q[0]}, 32'd12);
        check("ld_r4", {24'd0, dut.regs_q[4]}, 32'd12);
        check("ld_r5_untouched", {24'd0, dut.regs_q[5]}, 32'd0);

        // Re-run LDI R0 at 00, fetch the next one, then reset mid-EXEC
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_pc", {24'd0, rom_address}, 32'h2);
        #2 reset = 1'b0;
        #1;
        check("async_pc", {24'd0, rom_address}, 32'h0);
        check("async_r2", {24'd0, dut.regs_q[2]}, 32'h0);
        check("async_r4", {24'd0, dut.regs_q[4]}, 32'h0);
        check("async_mem0", {24'd0, dut.mem_q[0]}, 32'h0);
        check("async_z", {31'd0, dut.z_q}, 32'h0);
        check("async_state", {30'd0, dut.state_q}, {30'd0, cpu_pkg::S_FETCH});
        @(negedge clk);
        reset = 1'b1;

        // Opcode 1111 at address 02
        clear_rom();
        put(8'h00, 8'h10, 8'h05);   // LDI R0,5
        put(8'h02, 8'hF0, 8'h00);   // HALT / NOP
        put(8'h04, 8'h11, 8'h07);   // LDI R1,7
        do_reset();
        repeat (16) @(negedge clk);
        check("op15_r0", {24'd0, dut.regs_q[0]}, 32'd5);
`ifdef CPU_HALT_EN
        check("halt_pc", {24'd0, rom_address}, 32'h2);
        check("halt_r1", {24'd0, dut.regs_q[1]}, 32'd0);
        do_reset();
        check("halt_cleared_pc", {24'd0, rom_address}, 32'h0);
        repeat (2) @(negedge clk);
        check("halt_cleared_run", {24'd0, rom_address}, 32'h2);
`else
        check("op15_nop_r1", {24'd0, dut.regs_q[1]}, 32'd7);
        check("op15_nop_pc", {24'd0, rom_address}, 32'h10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
